// File: rtl/spmv_csr_fetch.sv
// CSR fetch sequencer for SpMV: loads row pointers, then streams nonzero/vector reads with an aligned 1-based count.
// Optional pointer sanity check is enabled by defining SPMV_FETCH_PTRCHK_EN.
`timescale 1ns/1ps

module spmv_csr_fetch #(
    parameter int unsigned PTR_N     = 17,
    parameter int unsigned CNT_EXTRA = 1,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_start,
    output logic                o_ptr_ren,
    output logic [4:0]          o_ptr_addr,
    input  logic [7:0]          i_ptr_rdata,
    output logic                o_nz_ren,
    output logic [7:0]          o_nz_addr,
    input  logic [3:0]          i_col_idx,
    output logic                o_val_ren,
    output logic [7:0]          o_val_addr,
    output logic                o_vec_ren,
    output logic [3:0]          o_vec_addr,
    output logic [PTR_N*8-1:0]  o_row_ptr,
    output logic [7:0]          o_count,
    output logic                o_count_vld,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    localparam int unsigned PW  = 8;
    localparam int unsigned AW  = 5;
    localparam int unsigned KW  = 8;
    localparam int unsigned CW  = 4;
    localparam int unsigned DCW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                         state_q;
    logic                           ptr_ren_q;
    logic [AW-1:0]                  ptr_addr_q;
    logic                           cap_vld_q;
    logic [AW-1:0]                  cap_idx_q;
    logic [PTR_N-1:0][PW-1:0]       row_ptr_q;
    logic                           nz_ren_q;
    logic [KW-1:0]                  nz_addr_q;
    logic                           val_ren_q;
    logic [KW-1:0]                  val_addr_q;
    logic [CNT_EXTRA:0][KW-1:0]     cnt_q;
    logic [CNT_EXTRA:0]             cnt_vld_q;
    logic [DCW-1:0]                 drain_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           err_q;
    logic                           ptr_bad_c;
    logic [KW-1:0]                  nnz_last_c;

    assign nnz_last_c = KW'(row_ptr_q[PTR_N-1] - 8'd1);

`ifdef SPMV_FETCH_PTRCHK_EN
    logic [PTR_N-1:0][PW-1:0] cand_c;

    // Check uses the last entry straight off the read port, since it lands on the decision edge.
    always_comb begin
        cand_c          = row_ptr_q;
        cand_c[PTR_N-1] = i_ptr_rdata;
        ptr_bad_c       = (cand_c[0] != '0);
        for (int i = 1; i < int'(PTR_N); i++) begin
            if (cand_c[i] < cand_c[i-1]) begin
                ptr_bad_c = 1'b1;
            end
        end
    end
`else
    assign ptr_bad_c = 1'b0;
`endif

    // Sequencer state, memory-port enables and the count pipeline.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            ptr_ren_q  <= 1'b0;
            ptr_addr_q <= '0;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= '0;
            row_ptr_q  <= '0;
            nz_ren_q   <= 1'b0;
            nz_addr_q  <= '0;
            val_ren_q  <= 1'b0;
            val_addr_q <= '0;
            cnt_q      <= '0;
            cnt_vld_q  <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            cap_vld_q    <= ptr_ren_q;
            cap_idx_q    <= ptr_addr_q;
            val_ren_q    <= nz_ren_q;
            val_addr_q   <= nz_addr_q;
            cnt_vld_q[0] <= val_ren_q;
            cnt_q[0]     <= val_ren_q ? KW'(val_addr_q + 8'd1) : '0;
            for (int i = 1; i <= int'(CNT_EXTRA); i++) begin
                cnt_vld_q[i] <= cnt_vld_q[i-1];
                cnt_q[i]     <= cnt_q[i-1];
            end
            if (cap_vld_q) begin
                row_ptr_q[cap_idx_q] <= i_ptr_rdata;
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q    <= ST_LOAD;
                        ptr_ren_q  <= 1'b1;
                        ptr_addr_q <= '0;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ptr_ren_q) begin
                        if (ptr_addr_q == AW'(PTR_N - 1)) begin
                            ptr_ren_q  <= 1'b0;
                            ptr_addr_q <= '0;
                        end else begin
                            ptr_addr_q <= AW'(ptr_addr_q + 5'd1);
                        end
                    end
                    // Last entry carries nnz; decide on the edge that captures it.
                    if (cap_vld_q && (cap_idx_q == AW'(PTR_N - 1))) begin
                        if (ptr_bad_c || (i_ptr_rdata == '0)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            if (ptr_bad_c) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            state_q   <= ST_RUN;
                            nz_ren_q  <= 1'b1;
                            nz_addr_q <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (nz_addr_q == nnz_last_c) begin
                        state_q   <= ST_DRAIN;
                        nz_ren_q  <= 1'b0;
                        nz_addr_q <= '0;
                        drain_q   <= '0;
                    end else begin
                        nz_addr_q <= KW'(nz_addr_q + 8'd1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DCW'(DRAIN_CYC - 1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= DCW'(drain_q + 8'd1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ptr_ren   = ptr_ren_q;
    assign o_ptr_addr  = ptr_addr_q;
    assign o_nz_ren    = nz_ren_q;
    assign o_nz_addr   = nz_addr_q;
    assign o_val_ren   = val_ren_q;
    assign o_val_addr  = val_addr_q;
    assign o_vec_ren   = val_ren_q;
    // Column index returns in the cycle after the nz read; forward it straight to the vector port.
    assign o_vec_addr  = val_ren_q ? i_col_idx : CW'(0);
    assign o_row_ptr   = row_ptr_q;
    assign o_count     = cnt_q[CNT_EXTRA];
    assign o_count_vld = cnt_vld_q[CNT_EXTRA];
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_spmv_csr_fetch.sv
// Directed bench for spmv_csr_fetch: cycle-offset model of a whole fetch plus literal spot checks.
`timescale 1ns/1ps

module tb_spmv_csr_fetch;

    localparam int CNT_EXTRA = 1;
    localparam int DRAIN_CYC = 4;
    localparam int LOAD_LEN  = 18;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic         ptr_ren;
    logic [4:0]   ptr_addr;
    logic [7:0]   ptr_rdata;
    logic         nz_ren;
    logic [7:0]   nz_addr;
    logic [3:0]   col_idx;
    logic         val_ren;
    logic [7:0]   val_addr;
    logic         vec_ren;
    logic [3:0]   vec_addr;
    logic [135:0] row_ptr;
    logic [7:0]   count;
    logic         count_vld;
    logic         busy;
    logic         done;
    logic         err;

    spmv_csr_fetch dut (
        .i_clk(clk), .i_rstn(rst_n), .i_start(i_start),
        .o_ptr_ren(ptr_ren), .o_ptr_addr(ptr_addr), .i_ptr_rdata(ptr_rdata),
        .o_nz_ren(nz_ren), .o_nz_addr(nz_addr), .i_col_idx(col_idx),
        .o_val_ren(val_ren), .o_val_addr(val_addr),
        .o_vec_ren(vec_ren), .o_vec_addr(vec_addr),
        .o_row_ptr(row_ptr), .o_count(count), .o_count_vld(count_vld),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ptr_mem [32];
    logic [3:0] col_mem [256];

    always @(posedge clk) if (ptr_ren) ptr_rdata <= ptr_mem[ptr_addr];
    always @(posedge clk) if (nz_ren)  col_idx   <= col_mem[nz_addr];

    logic start_smp;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) start_smp <= 1'b0;
        else        start_smp <= i_start;

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Model: everything is a function of the cycle offset r from the accepted start.
    bit                  act;
    int                  cyc, c0, r, nnz, done_off;
    bit                  bad, short_run;
    logic [7:0]          snap [17];
    logic [16:0][7:0]    exp_rp;
    logic                merr;

    always @(negedge clk) begin
        if (!rst_n) begin
            act = 1'b0; cyc = 0; c0 = 0; done_off = 0;
            exp_rp = '0; merr = 1'b0;
        end else begin
            cyc++;
            if (start_smp && (!act || (cyc - 1 - c0) > done_off)) begin
                act = 1'b1; c0 = cyc; merr = 1'b0;
                for (int i = 0; i < 17; i++) snap[i] = ptr_mem[i];
                nnz = int'(snap[16]);
                bad = 1'b0;
`ifdef SPMV_FETCH_PTRCHK_EN
                if (snap[0] != 8'd0) bad = 1'b1;
                for (int i = 0; i < 16; i++) if (snap[i+1] < snap[i]) bad = 1'b1;
`endif
                short_run = bad || (nnz == 0);
                done_off  = short_run ? LOAD_LEN : LOAD_LEN + nnz + DRAIN_CYC;
            end
            begin
                logic e_pren, e_nren, e_vren, e_cvld, e_busy, e_done;
                int   e_paddr, e_naddr, e_vaddr, e_vec, e_cnt;
                e_pren = 0; e_nren = 0; e_vren = 0; e_cvld = 0; e_busy = 0; e_done = 0;
                e_paddr = 0; e_naddr = 0; e_vaddr = 0; e_vec = 0; e_cnt = 0;
                if (act) begin
                    r = cyc - c0;
                    if (r >= 2 && r <= 18) exp_rp[r-2] = snap[r-2];
                    if (r == LOAD_LEN && bad) merr = 1'b1;
                    if (r <= 16) begin e_pren = 1; e_paddr = r; end
                    if (!short_run && r >= 18 && r < 18 + nnz) begin e_nren = 1; e_naddr = r - 18; end
                    if (!short_run && r >= 19 && r < 19 + nnz) begin
                        e_vren = 1; e_vaddr = r - 19; e_vec = int'(col_mem[r-19]);
                    end
                    if (!short_run && r >= 20 + CNT_EXTRA && r < 20 + CNT_EXTRA + nnz) begin
                        e_cvld = 1; e_cnt = r - 19 - CNT_EXTRA;
                    end
                    e_busy = (r <= done_off);
                    e_done = (r == done_off);
                end
                chk("ptr_ren", 136'(ptr_ren), 136'(e_pren));
                if (e_pren) chk("ptr_addr", 136'(ptr_addr), 136'(e_paddr));
                chk("nz_ren", 136'(nz_ren), 136'(e_nren));
                if (e_nren) chk("nz_addr", 136'(nz_addr), 136'(e_naddr));
                chk("val_ren", 136'(val_ren), 136'(e_vren));
                chk("vec_ren", 136'(vec_ren), 136'(e_vren));
                if (e_vren) chk("val_addr", 136'(val_addr), 136'(e_vaddr));
                chk("vec_addr", 136'(vec_addr), 136'(e_vec));
                chk("count", 136'(count), 136'(e_cnt));
                chk("count_vld", 136'(count_vld), 136'(e_cvld));
                chk("busy", 136'(busy), 136'(e_busy));
                chk("done", 136'(done), 136'(e_done));
                chk("err", 136'(err), 136'(merr));
                chk("row_ptr", row_ptr, exp_rp);
            end
        end
    end

    task automatic fill_ptr(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                            input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] rest);
        ptr_mem[0] = p0; ptr_mem[1] = p1; ptr_mem[2] = p2; ptr_mem[3] = p3; ptr_mem[4] = p4;
        for (int i = 5; i < 32; i++) ptr_mem[i] = rest;
    endtask

    // One start pulse, then watch until a few cycles past o_done.
    task automatic run(input bit inject, output int t_done, output int t_issue, output int t_cnt,
                       output int first_cnt, output int v3, output int va3, output int ndone);
        bit k3;
        t_done = -1; t_issue = -1; t_cnt = -1; first_cnt = -1; v3 = -1; va3 = -1; ndone = 0; k3 = 0;
        @(negedge clk);
        i_start = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            i_start = (inject && n == 20);
            if (k3) begin
                v3  = vec_ren ? int'(vec_addr) : -1;
                va3 = int'(val_addr);
                k3  = 0;
            end
            if (nz_ren && nz_addr == 8'd3) k3 = 1;
            if (nz_ren && t_issue < 0) t_issue = n;
            if (count_vld && t_cnt < 0) begin t_cnt = n; first_cnt = int'(count); end
            if (done) begin ndone++; if (t_done < 0) t_done = n; end
            if (t_done >= 0 && n >= t_done + 3) break;
        end
        i_start = 1'b0;
        if (t_done < 0) chk_i("done_timeout", 0, 1);
    endtask

    initial begin
        int  td, ti, tc, fc, v3, va3, nd, found;
        rst_n = 1'b0; i_start = 1'b0;
        for (int i = 0; i < 256; i++) col_mem[i] = 4'((i * 5 + 2) % 16);
        col_mem[3] = 4'd7;
        fill_ptr(8'd0, 8'd2, 8'd2, 8'd5, 8'd5, 8'd5);

        repeat (3) @(negedge clk);
        chk("rst_busy", 136'(busy), 136'(0));
        chk("rst_done", 136'(done), 136'(0));
        chk("rst_count", 136'(count), 136'(0));
        chk("rst_row_ptr", row_ptr, 136'(0));
        chk("rst_nz_ren", 136'(nz_ren), 136'(0));
        chk("rst_err", 136'(err), 136'(0));
        #1 rst_n = 1'b1;

        // Rows 0..3 with 2,0,3,0 nonzeros; start pulse injected mid-RUN must be ignored.
        run(1'b1, td, ti, tc, fc, v3, va3, nd);
        chk_i("a_done_cycle", td, 27);
        chk_i("a_first_issue", ti, 18);
        chk_i("a_count_latency", tc - ti, 3);
        chk_i("a_first_count", fc, 1);
        chk_i("a_vec_addr_k3", v3, 7);
        chk_i("a_val_addr_k3", va3, 3);
        chk_i("a_done_pulses", nd, 1);
        chk("a_row_ptr2", 136'(row_ptr[23:16]), 136'(2));
        chk("a_row_ptr3", 136'(row_ptr[31:24]), 136'(5));

        // Empty matrix.
        fill_ptr(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        run(1'b0, td, ti, tc, fc, v3, va3, nd);
        chk_i("z_done_cycle", td, 18);
        chk_i("z_no_issue", ti, -1);
        chk_i("z_no_count", tc, -1);
        chk_i("z_done_pulses", nd, 1);

        // Non-monotonic pointers: row_ptr[4]=3 < row_ptr[3]=5.
        fill_ptr(8'd0, 8'd2, 8'd2, 8'd5, 8'd3, 8'd5);
        run(1'b0, td, ti, tc, fc, v3, va3, nd);
`ifdef SPMV_FETCH_PTRCHK_EN
        chk("c_err", 136'(err), 136'(1));
        chk_i("c_done_cycle", td, 18);
        chk_i("c_no_issue", ti, -1);
`else
        chk("c_err", 136'(err), 136'(0));
        chk_i("c_done_cycle", td, 27);
`endif
        chk_i("c_done_pulses", nd, 1);

        fill_ptr(8'd0, 8'd2, 8'd2, 8'd5, 8'd5, 8'd5);
        run(1'b0, td, ti, tc, fc, v3, va3, nd);
        chk("c_err_cleared", 136'(err), 136'(0));
        chk_i("c2_done_cycle", td, 27);

        // Reset while k=2 is being issued.
        found = 0;
        @(negedge clk);
        i_start = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (nz_ren && nz_addr == 8'd2) begin found = 1; break; end
        end
        chk_i("r_reached_k2", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("r_nz_ren", 136'(nz_ren), 136'(0));
        chk("r_nz_addr", 136'(nz_addr), 136'(0));
        chk("r_val_ren", 136'(val_ren), 136'(0));
        chk("r_vec_addr", 136'(vec_addr), 136'(0));
        chk("r_busy", 136'(busy), 136'(0));
        chk("r_row_ptr", row_ptr, 136'(0));
        nd = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk_i("r_no_done", nd, 0);
        #1 rst_n = 1'b1;

        fill_ptr(8'd0, 8'd1, 8'd3, 8'd3, 8'd3, 8'd3);
        run(1'b0, td, ti, tc, fc, v3, va3, nd);
        chk_i("d_done_cycle", td, 25);
        chk_i("d_done_pulses", nd, 1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
